// File: rtl/traffic_light_ctrl.sv
// Round-robin intersection controller: each direction in turn gets
// GREEN -> YELLOW -> ALL-RED, with durations counted in timebase ticks.
// A latched pedestrian request shortens the requesting direction's green.
// Optional feature macro: TRAFFIC_LIGHT_FLASH_EN adds a `flash` input and a
// FLASH state that blinks every yellow lamp and restarts the cycle on exit.
module traffic_light_ctrl #(
  parameter int NUM_DIR    = 2,
  parameter int TIMER_W    = 8,
  parameter int GREEN_T    = 20,
  parameter int YELLOW_T   = 3,
  parameter int ALLRED_T   = 2,
  parameter int PED_WINDOW = 10,
  parameter int PED_SKIP   = 10,
  localparam int DIR_W     = (NUM_DIR > 1) ? $clog2(NUM_DIR) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
`ifdef TRAFFIC_LIGHT_FLASH_EN
  input  logic               flash,
`endif
  input  logic [NUM_DIR-1:0] ped_req,
  output logic [NUM_DIR-1:0] red,
  output logic [NUM_DIR-1:0] yellow,
  output logic [NUM_DIR-1:0] green,
  output logic [DIR_W-1:0]   active_dir,
  output logic [NUM_DIR-1:0] ped_ack
);

  localparam int CNT_MAX = (1 << TIMER_W) - 1;

  if (NUM_DIR < 2 || NUM_DIR > 8 ||
      GREEN_T < 1 || GREEN_T > CNT_MAX ||
      YELLOW_T < 1 || YELLOW_T > CNT_MAX ||
      ALLRED_T < 1 || ALLRED_T > CNT_MAX ||
      PED_SKIP < 0 || PED_SKIP >= GREEN_T) begin : g_bad_params
    $error("traffic_light_ctrl: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    S_GREEN,
    S_YELLOW,
    S_ALLRED
`ifdef TRAFFIC_LIGHT_FLASH_EN
    , S_FLASH
`endif
  } state_t;

  state_t               state, nxt_state;
  logic [TIMER_W-1:0]   cnt, nxt_cnt;
  logic [DIR_W-1:0]     nxt_dir;
  logic [NUM_DIR-1:0]   ped_lat;
  logic [NUM_DIR-1:0]   ack_mask, cur_mask, nxt_mask;
  logic [NUM_DIR-1:0]   nxt_red, nxt_yellow, nxt_green;
`ifdef TRAFFIC_LIGHT_FLASH_EN
  logic                 tog, nxt_tog;
`endif

  // Last counter value of a state; the state ends on the tick that sees it.
  function automatic logic [TIMER_W-1:0] last_cnt(input state_t s);
    case (s)
      S_GREEN:  return TIMER_W'(GREEN_T - 1);
      S_YELLOW: return TIMER_W'(YELLOW_T - 1);
      default:  return TIMER_W'(ALLRED_T - 1);
    endcase
  endfunction

  // Pedestrian skip: add 1+PED_SKIP with one spare bit, clamp to the last green count.
  function automatic logic [TIMER_W-1:0] skip_cnt(input logic [TIMER_W-1:0] c);
    logic [TIMER_W:0] s;
    s = {1'b0, c} + (TIMER_W+1)'(PED_SKIP + 1);
    if (s > (TIMER_W+1)'(GREEN_T - 1))
      return TIMER_W'(GREEN_T - 1);
    return s[TIMER_W-1:0];
  endfunction

  function automatic logic [NUM_DIR-1:0] dir_onehot(input logic [DIR_W-1:0] d);
    logic [NUM_DIR-1:0] m;
    m    = '0;
    m[d] = 1'b1;
    return m;
  endfunction

  function automatic logic [DIR_W-1:0] next_dir(input logic [DIR_W-1:0] d);
    return (d == DIR_W'(NUM_DIR - 1)) ? '0 : d + 1'b1;
  endfunction

  // Next-state, counter, pedestrian consumption and lamp decode of the next state.
  always_comb begin
    nxt_state = state;
    nxt_dir   = active_dir;
    nxt_cnt   = cnt;
    ack_mask  = '0;
    cur_mask  = dir_onehot(active_dir);
`ifdef TRAFFIC_LIGHT_FLASH_EN
    nxt_tog   = tog;
    if (flash) begin
      nxt_state = S_FLASH;
      nxt_cnt   = '0;
      nxt_tog   = (state == S_FLASH) ? (tog ^ tick) : 1'b1;
    end else if (state == S_FLASH) begin
      // Leaving flash is a clean restart, identical to coming out of reset.
      nxt_state = S_ALLRED;
      nxt_dir   = DIR_W'(NUM_DIR - 1);
      nxt_cnt   = '0;
    end else
`endif
    if (tick) begin
      if (cnt == last_cnt(state)) begin
        nxt_cnt = '0;
        case (state)
          S_GREEN:  nxt_state = S_YELLOW;
          S_YELLOW: nxt_state = S_ALLRED;
          default: begin
            nxt_state = S_GREEN;
            nxt_dir   = next_dir(active_dir);
          end
        endcase
      end else if (state == S_GREEN && ped_lat[active_dir] &&
                   32'(cnt) <= PED_WINDOW) begin
        nxt_cnt  = skip_cnt(cnt);
        ack_mask = cur_mask;
      end else begin
        nxt_cnt = cnt + 1'b1;
      end
    end

    nxt_mask   = dir_onehot(nxt_dir);
    nxt_red    = '1;
    nxt_yellow = '0;
    nxt_green  = '0;
    case (nxt_state)
      S_GREEN: begin
        nxt_green = nxt_mask;
        nxt_red   = ~nxt_mask;
      end
      S_YELLOW: begin
        nxt_yellow = nxt_mask;
        nxt_red    = ~nxt_mask;
      end
`ifdef TRAFFIC_LIGHT_FLASH_EN
      S_FLASH: begin
        nxt_red    = '0;
        nxt_yellow = {NUM_DIR{nxt_tog}};
      end
`endif
      default: ;
    endcase
  end

  // Controller state, pedestrian latches and registered lamp/ack outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_ALLRED;
      active_dir <= DIR_W'(NUM_DIR - 1);
      cnt        <= '0;
      ped_lat    <= '0;
      red        <= '1;
      yellow     <= '0;
      green      <= '0;
      ped_ack    <= '0;
`ifdef TRAFFIC_LIGHT_FLASH_EN
      tog        <= 1'b1;
`endif
    end else begin
      state      <= nxt_state;
      active_dir <= nxt_dir;
      cnt        <= nxt_cnt;
      // A request arriving in the consuming cycle is a fresh request and survives.
      ped_lat    <= (ped_lat & ~ack_mask) | ped_req;
      red        <= nxt_red;
      yellow     <= nxt_yellow;
      green      <= nxt_green;
      ped_ack    <= ack_mask;
`ifdef TRAFFIC_LIGHT_FLASH_EN
      tog        <= nxt_tog;
`endif
    end
  end

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Bench for traffic_light_ctrl (NUM_DIR=2, default timing). Segments of
// {op, tick, ped_req, flash, cycles, expected lamps} are applied in order;
// expected outputs are queued when inputs are driven and popped after the edge.
module tb_traffic_light_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic [1:0] ped_req = 2'b00;
  logic [1:0] red, yellow, green, ped_ack;
  logic       active_dir;
`ifdef TRAFFIC_LIGHT_FLASH_EN
  logic       flash = 1'b0;
`endif

  traffic_light_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
`ifdef TRAFFIC_LIGHT_FLASH_EN
    .flash      (flash),
`endif
    .ped_req    (ped_req),
    .red        (red),
    .yellow     (yellow),
    .green      (green),
    .active_dir (active_dir),
    .ped_ack    (ped_ack)
  );

  always #5 clk = ~clk;

  // Observation word: {red, yellow, green, active_dir, ped_ack}
  localparam logic [8:0] AR1  = {2'b11, 2'b00, 2'b00, 1'b1, 2'b00};
  localparam logic [8:0] AR0  = {2'b11, 2'b00, 2'b00, 1'b0, 2'b00};
  localparam logic [8:0] G0   = {2'b10, 2'b00, 2'b01, 1'b0, 2'b00};
  localparam logic [8:0] G0A  = {2'b10, 2'b00, 2'b01, 1'b0, 2'b01};
  localparam logic [8:0] Y0   = {2'b10, 2'b01, 2'b00, 1'b0, 2'b00};
  localparam logic [8:0] G1   = {2'b01, 2'b00, 2'b10, 1'b1, 2'b00};
  localparam logic [8:0] G1A  = {2'b01, 2'b00, 2'b10, 1'b1, 2'b10};
  localparam logic [8:0] Y1   = {2'b01, 2'b10, 2'b00, 1'b1, 2'b00};
  localparam logic [8:0] FLON = {2'b00, 2'b11, 2'b00, 1'b0, 2'b00};
  localparam logic [8:0] FLOF = {2'b00, 2'b00, 2'b00, 1'b0, 2'b00};

  localparam int OP_RUN  = 0;
  localparam int OP_RST  = 1;
  localparam int OP_ARST = 2;

  typedef struct {
    int         op;
    bit         tk;
    logic [1:0] rq;
    bit         fl;
    int         n;
    logic [8:0] e;
  } seg_t;

  seg_t       tbl[$];
  logic [8:0] exp_q[$];
  int         n_chk = 0;
  int         n_err = 0;

  task automatic add(input int op, input bit tk, input logic [1:0] rq,
                     input bit fl, input int n, input logic [8:0] e);
    seg_t s;
    s.op = op; s.tk = tk; s.rq = rq; s.fl = fl; s.n = n; s.e = e;
    tbl.push_back(s);
  endtask

  task automatic run(input int n, input logic [8:0] e);
    add(OP_RUN, 1'b1, 2'b00, 1'b0, n, e);
  endtask

  task automatic chk(input string nm, input logic [8:0] got, input logic [8:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s r/y/g/dir/ack got %b_%b_%b_%b_%b required %b_%b_%b_%b_%b", nm,
               got[8:7], got[6:5], got[4:3], got[2], got[1:0],
               exp[8:7], exp[6:5], exp[4:3], exp[2], exp[1:0]);
    end
  endtask

  function automatic logic [8:0] obs();
    return {red, yellow, green, active_dir, ped_ack};
  endfunction

  initial begin
    seg_t       s;
    logic [8:0] e;

    // Scenario 1: free-running cycle with no requests, period 50 ticks.
    add(OP_RST, 1'b0, 2'b00, 1'b0, 0, AR1);
    run(1, AR1); run(20, G0); run(3, Y0); run(2, AR0);
    run(20, G1); run(3, Y1); run(2, AR1); run(20, G0);

    // Scenario 2: request at G0 cnt=4 shortens G0 to 10, G1 untouched.
    add(OP_RST, 1'b0, 2'b00, 1'b0, 0, AR1);
    run(1, AR1); run(5, G0);
    add(OP_RUN, 1'b1, 2'b01, 1'b0, 1, G0);
    run(1, G0A); run(3, G0); run(3, Y0); run(2, AR0);
    run(20, G1); run(3, Y1);

    // Scenario 3: late request in G1 is held until the next G1.
    add(OP_RST, 1'b0, 2'b00, 1'b0, 0, AR1);
    run(1, AR1); run(20, G0); run(3, Y0); run(2, AR0);
    run(16, G1);
    add(OP_RUN, 1'b1, 2'b10, 1'b0, 1, G1);
    run(3, G1); run(3, Y1); run(2, AR1); run(20, G0); run(3, Y0); run(2, AR0);
    run(1, G1); run(1, G1A); run(8, G1); run(3, Y1);

    // Scenario 4: tick held low during Y0 freezes everything.
    add(OP_RST, 1'b0, 2'b00, 1'b0, 0, AR1);
    run(1, AR1); run(20, G0); run(2, Y0);
    add(OP_RUN, 1'b0, 2'b00, 1'b0, 7, Y0);
    run(1, Y0); run(2, AR0); run(20, G1);

    // Scenario 5: asynchronous reset mid-G1, then a clean restart.
    add(OP_RST, 1'b0, 2'b00, 1'b0, 0, AR1);
    run(1, AR1); run(20, G0); run(3, Y0); run(2, AR0); run(7, G1);
    add(OP_ARST, 1'b0, 2'b00, 1'b0, 0, AR1);
    run(1, AR1); run(20, G0); run(3, Y0); run(2, AR0);
    run(20, G1); run(3, Y1); run(2, AR1); run(5, G0);

`ifdef TRAFFIC_LIGHT_FLASH_EN
    // Flash mid-G0: yellow blinks, request latched but not consumed until after restart.
    add(OP_RST, 1'b0, 2'b00, 1'b0, 0, AR1);
    run(1, AR1); run(5, G0);
    add(OP_RUN, 1'b1, 2'b00, 1'b1, 1, FLON);
    add(OP_RUN, 1'b1, 2'b01, 1'b1, 1, FLOF);
    add(OP_RUN, 1'b1, 2'b00, 1'b1, 1, FLON);
    add(OP_RUN, 1'b1, 2'b00, 1'b1, 1, FLOF);
    add(OP_RUN, 1'b1, 2'b00, 1'b1, 1, FLON);
    add(OP_RUN, 1'b1, 2'b00, 1'b1, 1, FLOF);
    run(2, AR1); run(1, G0); run(1, G0A); run(8, G0); run(1, Y0);
`endif

    for (int i = 0; i < tbl.size(); i++) begin
      s = tbl[i];
      case (s.op)
        OP_RST: begin
          tick = 1'b0; ped_req = 2'b00; rst = 1'b1;
`ifdef TRAFFIC_LIGHT_FLASH_EN
          flash = 1'b0;
`endif
          @(posedge clk);
          @(negedge clk);
          rst = 1'b0;
          #1;
          chk($sformatf("reset_seg%0d", i), obs(), s.e);
        end
        OP_ARST: begin
          @(posedge clk);
          #2;
          tick = 1'b0; ped_req = 2'b00; rst = 1'b1;
          #1;
          chk($sformatf("async_reset_seg%0d", i), obs(), s.e);
          @(negedge clk);
          @(negedge clk);
          rst = 1'b0;
          #1;
          chk($sformatf("async_release_seg%0d", i), obs(), s.e);
        end
        default: begin
          for (int c = 0; c < s.n; c++) begin
            tick    = s.tk;
            ped_req = s.rq;
`ifdef TRAFFIC_LIGHT_FLASH_EN
            flash   = s.fl;
`endif
            exp_q.push_back(s.e);
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            chk($sformatf("seg%0d_cyc%0d", i, c), obs(), e);
            if (red != 2'b00) begin
              n_chk++;
              if (!$onehot0(green | yellow)) begin
                n_err++;
                $display("FAIL onehot_seg%0d_cyc%0d green|yellow got %b required at most one bit",
                         i, c, green | yellow);
              end
            end
            @(negedge clk);
          end
        end
      endcase
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
